// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register: main drives out_data, skid absorbs one beat of backpressure.
// Optional performance counters are built when PIPE_STAGE_REG_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] main_data_p0, main_data_nxt;
  logic [WIDTH-1:0] skid_data_p0, skid_data_nxt;
  logic             main_vld_p0;
  logic             skid_vld_p0;
  logic             in_fire;
  logic             out_fire;

  // Valid bits come straight from the state register, keeping in_ready free of any out_ready path.
  assign main_vld_p0 = (state_p0 != ST_EMPTY);
  assign skid_vld_p0 = (state_p0 == ST_FULL);

  assign in_ready  = !skid_vld_p0 && !freeze;
  assign out_valid = main_vld_p0 && !freeze;
  assign out_data  = main_data_p0;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt     = state_p0;
    main_data_nxt = main_data_p0;
    skid_data_nxt = skid_data_p0;
    if (flush) begin
      state_nxt     = ST_EMPTY;
      main_data_nxt = BUBBLE_VAL;
      skid_data_nxt = BUBBLE_VAL;
    end else if (!freeze) begin
      case (state_p0)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_nxt = in_data;
            state_nxt     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_nxt = in_data;
          end else if (out_fire) begin
            main_data_nxt = BUBBLE_VAL;
            state_nxt     = ST_EMPTY;
          end else if (in_fire) begin
            skid_data_nxt = in_data;
            state_nxt     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data_nxt = skid_data_p0;
            skid_data_nxt = BUBBLE_VAL;
            state_nxt     = ST_ONE;
          end
        end
        default: begin
          state_nxt     = ST_EMPTY;
          main_data_nxt = BUBBLE_VAL;
          skid_data_nxt = BUBBLE_VAL;
        end
      endcase
    end
  end

  // ---- stage p0: state and entry registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p0     <= ST_EMPTY;
      main_data_p0 <= BUBBLE_VAL;
      skid_data_p0 <= BUBBLE_VAL;
    end else begin
      state_p0     <= state_nxt;
      main_data_p0 <= main_data_nxt;
      skid_data_p0 <= skid_data_nxt;
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // ---- stage p0: performance counters ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= sat_inc32(stall_cnt);
      if (flush)                   flush_cnt <= sat_inc16(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst, flush, freeze, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;

  logic        rst2, flush2, freeze2, in_valid2, out_ready2;
  logic [1:0]  in_data2;
  logic        in_ready2, out_valid2;
  logic [1:0]  out_data2;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_cnt, stall_cnt2;
  logic [15:0] flush_cnt, flush_cnt2;
  logic [31:0] stall_m;
  logic [15:0] flush_m;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] q[$];

  pipe_stage_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(2), .BUBBLE_VAL(2'h3)) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .freeze(freeze2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model view: up to two entries in acceptance order; head is what must be on out_data.
  task automatic sample();
    logic [31:0] head;
    @(negedge clk);
    head = (q.size() > 0) ? q[0] : 32'h0;
    chk("model_in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < 2) && !freeze});
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0) && !freeze});
    chk("model_out_data",  out_data, head);
`ifdef PIPE_STAGE_REG_PERF_EN
    chk("model_stall_cnt", stall_cnt, stall_m);
    chk("model_flush_cnt", {16'd0, flush_cnt}, {16'd0, flush_m});
`endif
  endtask

  task automatic adv();
    bit ov, ir;
    @(posedge clk);
    ov = (q.size() > 0) && !freeze;
    ir = (q.size() < 2) && !freeze;
    if (!rst) begin
      q.delete();
`ifdef PIPE_STAGE_REG_PERF_EN
      stall_m = 32'd0;
      flush_m = 16'd0;
`endif
    end else begin
`ifdef PIPE_STAGE_REG_PERF_EN
      if (ov && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
      if (flush && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
`endif
      if (flush) q.delete();
      else if (!freeze) begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic idle_inputs();
    flush = 0; freeze = 0; in_valid = 0; in_data = 32'h0; out_ready = 0;
  endtask

  initial begin
    rst = 0; idle_inputs();
    rst2 = 0; flush2 = 0; freeze2 = 0; in_valid2 = 0; in_data2 = 2'h0; out_ready2 = 0;
`ifdef PIPE_STAGE_REG_PERF_EN
    stall_m = 32'd0; flush_m = 16'd0;
`endif
    @(posedge clk); #1;
    adv(); adv();
    rst = 1; rst2 = 1;

    // reset state
    sample();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    adv();

    // streaming 1,2,3
    out_ready = 1;
    in_valid = 1; in_data = 32'h1; cyc();
    in_data = 32'h2; sample();
    chk("stream_v1", {31'd0, out_valid}, 32'd1); chk("stream_d1", out_data, 32'h1); adv();
    in_data = 32'h3; sample();
    chk("stream_v2", {31'd0, out_valid}, 32'd1); chk("stream_d2", out_data, 32'h2); adv();
    in_valid = 0; sample();
    chk("stream_v3", {31'd0, out_valid}, 32'd1); chk("stream_d3", out_data, 32'h3); adv();
    sample(); chk("stream_empty", {31'd0, out_valid}, 32'd0); adv();

    // backpressure A,B
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; cyc();
    in_data = 32'hB; sample(); chk("bp_ready_one", {31'd0, in_ready}, 32'd1); adv();
    in_valid = 0; sample();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0); chk("bp_head_a", out_data, 32'hA); adv();
    out_ready = 1; sample();
    chk("bp_out_a", out_data, 32'hA); chk("bp_ready_drain", {31'd0, in_ready}, 32'd0); adv();
    sample();
    chk("bp_out_b", out_data, 32'hB); chk("bp_ready_back", {31'd0, in_ready}, 32'd1); adv();
    cyc();

    // flush in FULL with in_valid carrying 0xC
    out_ready = 0; in_valid = 1;
    in_data = 32'h11; cyc();
    in_data = 32'h22; cyc();
    flush = 1; in_data = 32'hC; out_ready = 1; cyc();
    flush = 0; in_valid = 0; sample();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_data", out_data, 32'h0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1); adv();
    repeat (3) cyc();

    // flush in ONE while an input is accepted
    out_ready = 0; in_valid = 1; in_data = 32'h33; cyc();
    flush = 1; in_data = 32'h44; cyc();
    flush = 0; in_valid = 0; sample();
    chk("flush1_out_valid", {31'd0, out_valid}, 32'd0); adv();

    // freeze in ONE holding 0x5
    in_valid = 1; in_data = 32'h5; cyc();
    freeze = 1; in_data = 32'h66; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("frz_in_ready", {31'd0, in_ready}, 32'd0);
      chk("frz_out_valid", {31'd0, out_valid}, 32'd0);
      chk("frz_out_data", out_data, 32'h5);
      adv();
    end
    freeze = 0; in_valid = 0; sample();
    chk("frz_rel_valid", {31'd0, out_valid}, 32'd1);
    chk("frz_rel_data", out_data, 32'h5); adv();
    cyc();

    // flush beats freeze
    out_ready = 0; in_valid = 1; in_data = 32'h77; cyc();
    in_data = 32'h88; cyc();
    in_valid = 0; freeze = 1; flush = 1; cyc();
    freeze = 0; flush = 0; sample();
    chk("flushfrz_valid", {31'd0, out_valid}, 32'd0); adv();

    // reset mid-transfer on the 32-bit instance
    in_valid = 1; in_data = 32'h99; cyc();
    in_data = 32'hAA; cyc();
    rst = 0; in_valid = 0; flush = 1; freeze = 1; cyc();
    rst = 1; flush = 0; freeze = 0; sample();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1); adv();

    // WIDTH=2, BUBBLE_VAL=3 instance: reset in FULL
    sample();
    chk("w2_init_data", {30'd0, out_data2}, 32'h3); adv();
    in_valid2 = 1; in_data2 = 2'h1; cyc();
    in_data2 = 2'h2; cyc();
    in_valid2 = 0; sample();
    chk("w2_full_ready", {31'd0, in_ready2}, 32'd0);
    chk("w2_full_data", {30'd0, out_data2}, 32'h1); adv();
    rst2 = 0; cyc();
    rst2 = 1; sample();
    chk("w2_rst_data", {30'd0, out_data2}, 32'h3);
    chk("w2_rst_ready", {31'd0, in_ready2}, 32'd1);
    chk("w2_rst_valid", {31'd0, out_valid2}, 32'd0); adv();

`ifdef PIPE_STAGE_REG_PERF_EN
    // counters: 4 stalls, 2 flushes, then saturation of flush_cnt
    idle_inputs(); rst = 0; cyc(); rst = 1;
    in_valid = 1; in_data = 32'h5A; cyc();
    in_valid = 0; repeat (4) cyc();
    out_ready = 1; flush = 1; repeat (2) cyc();
    flush = 0; sample();
    chk("cnt_stall", stall_cnt, 32'd4);
    chk("cnt_flush", {16'd0, flush_cnt}, 32'd2); adv();
    flush = 1;
    for (int i = 0; i < 65540; i++) adv();
    sample();
    chk("cnt_flush_sat", {16'd0, flush_cnt}, 32'h0000_FFFF); adv();
    flush = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter BUBBLE_VAL, default all-zero (WIDTH bits): payload value held in empty entries.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  discards all held entries; highest-priority non-reset command.
REQ-006 freeze  input  1  blocks both transfers; all state held.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  head payload.

Function
REQ-013 Storage SHALL be two entries: main (drives out_data) and skid; each has a valid bit.
REQ-014 State encoding SHALL be EMPTY (none valid), ONE (main only) or FULL (main and skid).
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 in_ready SHALL equal !skid_valid & !freeze, with skid_valid taken from a register, so in_ready has no combinational path from out_ready.
REQ-017 out_valid SHALL equal main_valid & !freeze.
REQ-018 In EMPTY, in_fire SHALL load main and go to ONE, so out_valid rises the next cycle (latency 1).
REQ-019 In ONE, in_fire with out_fire SHALL reload main and stay in ONE (throughput 1 per cycle).
REQ-020 In ONE, out_fire without in_fire SHALL go to EMPTY and set main to BUBBLE_VAL.
REQ-021 In ONE, in_fire without out_fire SHALL load skid and go to FULL.
REQ-022 In FULL, out_fire SHALL move skid to main, set skid to BUBBLE_VAL and go to ONE; in_ready SHALL return to 1 the following cycle.
REQ-023 Entries SHALL leave in acceptance order; no entry is dropped or duplicated.
REQ-024 flush=1 SHALL clear both valid bits, set both entries to BUBBLE_VAL and go to EMPTY on the next edge; any in_fire or out_fire in that cycle SHALL have no effect on state.
REQ-025 flush SHALL take priority over freeze; freeze with no flush SHALL hold all state unchanged.
REQ-026 out_data SHALL equal BUBBLE_VAL whenever main_valid=0.

Reset
REQ-027 rst=0 at a rising edge SHALL force EMPTY, main and skid to BUBBLE_VAL, and all counters to 0; rst SHALL override flush and freeze.
REQ-028 After reset, in_ready=1 (if freeze=0), out_valid=0 and out_data=BUBBLE_VAL; a reset asserted mid-transfer SHALL discard held entries.

Configuration
REQ-029 When macro PIPE_STAGE_REG_PERF_EN is defined, the block SHALL add output stall_cnt (32 bits), counting cycles with out_valid & !out_ready, and output flush_cnt (16 bits), counting cycles with flush=1; both SHALL saturate at all-ones and clear on reset.
REQ-030 When PIPE_STAGE_REG_PERF_EN is undefined, stall_cnt and flush_cnt and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Streaming test: WIDTH=32 with out_ready=1; send 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 on the next three cycles, with out_valid=1 on each.
REQ-032 Backpressure test: send 0xA then 0xB with out_ready=0 -> FULL and in_ready=0; raise out_ready -> out_data shows 0xA then 0xB, and in_ready=1 one cycle after 0xA leaves.
REQ-033 Flush test: in FULL, pulse flush together with in_valid carrying 0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, and 0xC is never output.
REQ-034 Freeze test: in ONE holding 0x5, hold freeze=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, state unchanged; after release, out_data=0x5 with out_valid=1.
REQ-035 Reset test: BUBBLE_VAL=0x3 and WIDTH=2; assert rst=0 in FULL -> next cycle EMPTY, out_data=0x3, in_ready=1.
REQ-036 Counter test (macro defined): 4 stall cycles and 2 flush cycles -> stall_cnt=4 and flush_cnt=2; with flush_cnt preset near all-ones, it saturates at 0xFFFF.
